tempsense_sar_ctrl: RTL and testbench

Successive-approximation measurement controller for the `tempsense` delay cell. It replaces the linear DAC sweep with a binary search, so one conversion takes N_VDAC trials instead of 2**N_VDAC. It sequences the cell through precharge, transition, measure and evaluate per trial, and accepts conversion requests from a `start` strobe or from a built-in periodic trigger. It sits between the top-level IO logic and the `tempsense` instance, and its `result` feeds the calibration LUT and the `bin2dec` path.

---
 rtl/tempsense_pkg.sv | 59 +++++
 rtl/tempsense_sar_ctrl_if.sv | 25 ++
 rtl/tempsense_trigger.sv | 37 +++
 rtl/tempsense_sar_ctrl.sv | 167 ++++++++++++++++
 tb/tb_tempsense_sar_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tempsense_pkg.sv
// Shared types for the tempsense SAR controller: FSM states, per-phase output
// encodings and the DAC end-point constants.
package tempsense_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRECHARGE  = 3'd1,
        ST_TRANSITION = 3'd2,
        ST_MEASURE    = 3'd3,
        ST_EVALUATE   = 3'd4,
        ST_DONE       = 3'd5
    } sar_state_e;

    typedef enum logic [1:0] {
        DAC_SEL_MAX   = 2'd0,
        DAC_SEL_MIN   = 2'd1,
        DAC_SEL_TRIAL = 2'd2
    } dac_sel_e;

    typedef struct packed {
        logic     dac_en;
        logic     precharge_n;
        dac_sel_e dac_sel;
        logic     busy;
    } phase_enc_t;

    localparam phase_enc_t ENC_IDLE =
        '{dac_en: 1'b0, precharge_n: 1'b0, dac_sel: DAC_SEL_MAX, busy: 1'b0};
    localparam phase_enc_t ENC_PRECHARGE =
        '{dac_en: 1'b1, precharge_n: 1'b0, dac_sel: DAC_SEL_MAX, busy: 1'b1};
    localparam phase_enc_t ENC_TRANSITION =
        '{dac_en: 1'b1, precharge_n: 1'b1, dac_sel: DAC_SEL_MIN, busy: 1'b1};
    localparam phase_enc_t ENC_MEASURE =
        '{dac_en: 1'b1, precharge_n: 1'b1, dac_sel: DAC_SEL_TRIAL, busy: 1'b1};
    localparam phase_enc_t ENC_EVALUATE =
        '{dac_en: 1'b1, precharge_n: 1'b1, dac_sel: DAC_SEL_TRIAL, busy: 1'b1};

    function automatic int unsigned vmax(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

    function automatic int unsigned vmin(input int unsigned n);
        return ((32'd1 << n) >> n) - 32'd1;
    endfunction

    // DONE drives the same pins as IDLE, so it shares the idle encoding.
    function automatic phase_enc_t phase_enc(input sar_state_e st);
        phase_enc_t enc;
        case (st)
            ST_PRECHARGE:  enc = ENC_PRECHARGE;
            ST_TRANSITION: enc = ENC_TRANSITION;
            ST_MEASURE:    enc = ENC_MEASURE;
            ST_EVALUATE:   enc = ENC_EVALUATE;
            default:       enc = ENC_IDLE;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/tempsense_sar_ctrl_if.sv
// Control/measurement bundle between the IO logic, the SAR controller and the
// tempsense delay cell.
interface tempsense_sar_ctrl_if #(
    parameter int N_VDAC = 6
);
    logic              start;
    logic              auto_en;
    logic              tempdelay;
    logic [N_VDAC-1:0] dac_data;
    logic              dac_en;
    logic              precharge_n;
    logic              busy;
    logic [N_VDAC-1:0] result;
    logic              valid;

    modport master (
        input  start, auto_en, tempdelay,
        output dac_data, dac_en, precharge_n, busy, result, valid
    );

    modport slave (
        output start, auto_en, tempdelay,
        input  dac_data, dac_en, precharge_n, busy, result, valid
    );
endinterface

// File: rtl/tempsense_trigger.sv
// Periodic conversion trigger: free-running counter whose wrap raises a
// one-deep pending request, cleared when the controller accepts it.
module tempsense_trigger #(
    parameter int N_PERIOD = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic auto_en,
    input  logic take,
    output logic pending
);

    logic [N_PERIOD-1:0] period_ctr_q, period_ctr_d;
    logic                pending_q, pending_d;
    logic                tick_s;

    // A tick that lands on the same edge as a take re-arms the request.
    always_comb begin
        period_ctr_d = period_ctr_q + {{(N_PERIOD-1){1'b0}}, 1'b1};
        tick_s       = (period_ctr_d == {N_PERIOD{1'b0}});
        pending_d    = (pending_q & ~take) | (tick_s & auto_en);
    end

    // Counter and request flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_ctr_q <= {N_PERIOD{1'b0}};
            pending_q    <= 1'b0;
        end else begin
            period_ctr_q <= period_ctr_d;
            pending_q    <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/tempsense_sar_ctrl.sv
// Successive-approximation controller for the tempsense delay cell: resolves
// N_VDAC bits MSB first, one precharge/transition/measure/evaluate trial each.
module tempsense_sar_ctrl
    import tempsense_pkg::*;
#(
    parameter int N_VDAC      = 6,
    parameter int MEAS_CYCLES = 1,
    parameter int N_PERIOD    = 14
) (
    input  logic                clk,
    input  logic                reset,
    tempsense_sar_ctrl_if.master bus
);

    localparam int BIT_W  = (N_VDAC > 1) ? $clog2(N_VDAC) : 1;
    localparam int MEAS_W = (MEAS_CYCLES > 1) ? $clog2(MEAS_CYCLES) : 1;

    localparam logic [BIT_W-1:0]  BIT_MSB   = BIT_W'(N_VDAC - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = {{(BIT_W-1){1'b0}}, 1'b1};
    localparam logic [MEAS_W-1:0] MEAS_LAST = MEAS_W'(MEAS_CYCLES - 1);
    localparam logic [MEAS_W-1:0] MEAS_ONE  = {{(MEAS_W-1){1'b0}}, 1'b1};
    localparam logic [N_VDAC-1:0] DAC_MAX   = N_VDAC'(vmax(N_VDAC));
    localparam logic [N_VDAC-1:0] DAC_MIN   = N_VDAC'(vmin(N_VDAC));
    localparam logic [N_VDAC-1:0] TRIAL_ONE = {{(N_VDAC-1){1'b0}}, 1'b1};

    sar_state_e        state_q, state_d;
    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic [N_VDAC-1:0] work_q, work_d;
    logic [MEAS_W-1:0] meas_ctr_q, meas_ctr_d;
    logic [N_VDAC-1:0] result_q, result_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [N_VDAC-1:0] dac_data_q, dac_data_d;
    logic              dac_en_q, dac_en_d;
    logic              precharge_n_q, precharge_n_d;

    logic [N_VDAC-1:0] trial_s;
    logic [N_VDAC-1:0] trial_next_s;
    phase_enc_t        enc_s;
    logic              take_s;
    logic              pending_s;

    tempsense_trigger #(
        .N_PERIOD (N_PERIOD)
    ) u_trigger (
        .clk     (clk),
        .reset   (reset),
        .auto_en (bus.auto_en),
        .take    (take_s),
        .pending (pending_s)
    );

    // Sequencer: trial order, bit pointer, working code and measure dwell.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        work_d     = work_q;
        meas_ctr_d = meas_ctr_q;
        take_s     = 1'b0;
        trial_s    = work_q | (TRIAL_ONE << bit_idx_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.start || pending_s) begin
                    state_d   = ST_PRECHARGE;
                    bit_idx_d = BIT_MSB;
                    work_d    = {N_VDAC{1'b0}};
                    take_s    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRECHARGE: begin
                state_d = ST_TRANSITION;
            end
            ST_TRANSITION: begin
                state_d    = ST_MEASURE;
                meas_ctr_d = {MEAS_W{1'b0}};
            end
            ST_MEASURE: begin
                if (meas_ctr_q == MEAS_LAST) begin
                    state_d    = ST_EVALUATE;
                    meas_ctr_d = {MEAS_W{1'b0}};
                end else begin
                    meas_ctr_d = meas_ctr_q + MEAS_ONE;
                end
            end
            ST_EVALUATE: begin
                // A slow cell (tempdelay low) means the trial code is still at or below the threshold.
                if (!bus.tempdelay) begin
                    work_d = trial_s;
                end else begin
                    work_d = work_q;
                end
                if (bit_idx_q == {BIT_W{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    bit_idx_d = bit_idx_q - BIT_ONE;
                    state_d   = ST_PRECHARGE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin values for the upcoming state, so every output leaves a flop.
    always_comb begin
        enc_s        = phase_enc(state_d);
        trial_next_s = work_d | (TRIAL_ONE << bit_idx_d);
        dac_data_d   = DAC_MAX;
        case (enc_s.dac_sel)
            DAC_SEL_MAX:   dac_data_d = DAC_MAX;
            DAC_SEL_MIN:   dac_data_d = DAC_MIN;
            DAC_SEL_TRIAL: dac_data_d = trial_next_s;
            default:       dac_data_d = DAC_MAX;
        endcase
        dac_en_d      = enc_s.dac_en;
        precharge_n_d = enc_s.precharge_n;
        busy_d        = enc_s.busy;
        valid_d       = (state_d == ST_DONE);
        if (valid_d) begin
            result_d = work_d;
        end else begin
            result_d = result_q;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_idx_q     <= BIT_MSB;
            work_q        <= {N_VDAC{1'b0}};
            meas_ctr_q    <= {MEAS_W{1'b0}};
            result_q      <= {N_VDAC{1'b0}};
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            dac_data_q    <= DAC_MAX;
            dac_en_q      <= 1'b0;
            precharge_n_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            work_q        <= work_d;
            meas_ctr_q    <= meas_ctr_d;
            result_q      <= result_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
            dac_data_q    <= dac_data_d;
            dac_en_q      <= dac_en_d;
            precharge_n_q <= precharge_n_d;
        end
    end

    assign bus.dac_data    = dac_data_q;
    assign bus.dac_en      = dac_en_q;
    assign bus.precharge_n = precharge_n_q;
    assign bus.busy        = busy_q;
    assign bus.result      = result_q;
    assign bus.valid       = valid_q;

endmodule

// File: tb/tb_tempsense_sar_ctrl.sv
// Bench for tempsense_sar_ctrl: a lookup-table delay cell model drives two
// instances (1 and 3 measure cycles) and a binary-search model predicts them.
module tb_tempsense_sar_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tempsense_sar_ctrl_if #(.N_VDAC(6)) bus_a ();
    tempsense_sar_ctrl_if #(.N_VDAC(6)) bus_b ();

    logic start_a  = 1'b0;
    logic start_b  = 1'b0;
    logic auto_a   = 1'b0;
    logic auto_b   = 1'b0;
    logic force_td = 1'b0;
    logic lut [0:63];

    int n_checks = 0;
    int n_errors = 0;
    int unsigned ncyc;

    assign bus_a.start     = start_a;
    assign bus_a.auto_en   = auto_a;
    assign bus_a.tempdelay = force_td | lut[bus_a.dac_data];
    assign bus_b.start     = start_b;
    assign bus_b.auto_en   = auto_b;
    assign bus_b.tempdelay = force_td | lut[bus_b.dac_data];

    tempsense_sar_ctrl #(.N_VDAC(6), .MEAS_CYCLES(1), .N_PERIOD(5)) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_a)
    );

    tempsense_sar_ctrl #(.N_VDAC(6), .MEAS_CYCLES(3), .N_PERIOD(5)) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_b)
    );

    // Edges since reset release; the trigger wraps whenever this hits a multiple of 32.
    always @(posedge clk or posedge rst) begin
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] vec(input logic busy, input logic en, input logic pn,
                                       input logic [5:0] dac, input logic valid);
        return {busy, en, pn, dac, valid};
    endfunction

    function automatic logic [9:0] obs(input int sel);
        if (sel == 0) return {bus_a.busy, bus_a.dac_en, bus_a.precharge_n, bus_a.dac_data, bus_a.valid};
        else          return {bus_b.busy, bus_b.dac_en, bus_b.precharge_n, bus_b.dac_data, bus_b.valid};
    endfunction

    function automatic logic [5:0] res(input int sel);
        if (sel == 0) return bus_a.result;
        else          return bus_b.result;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_a = v;
        else          start_b = v;
    endtask

    task automatic set_thr(input int t);
        for (int v = 0; v < 64; v++) lut[v] = (v > t);
    endtask

    task automatic set_rand_lut();
        for (int v = 0; v < 64; v++) lut[v] = 1'($urandom_range(0, 1));
    endtask

    // Binary search against whatever the cell answers for each trial code.
    function automatic logic [5:0] model_result();
        logic [5:0] w;
        logic [5:0] t;
        w = 6'd0;
        for (int b = 5; b >= 0; b--) begin
            t = w | (6'd1 << b);
            if (!(force_td | lut[t])) w = t;
        end
        return w;
    endfunction

    // One start-triggered conversion, checked cycle by cycle; optional stray start at cycle 'inject'.
    task automatic run_conv(input int sel, input int inject);
        int         m;
        int         cyc;
        logic [5:0] w;
        logic [5:0] t;
        logic [9:0] e;
        m   = (sel == 0) ? 1 : 3;
        cyc = 0;
        w   = 6'd0;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        for (int b = 5; b >= 0; b--) begin
            t = w | (6'd1 << b);
            for (int k = 0; k < 3 + m; k++) begin
                if (k == 0)      e = vec(1'b1, 1'b1, 1'b0, 6'd63, 1'b0);
                else if (k == 1) e = vec(1'b1, 1'b1, 1'b1, 6'd0, 1'b0);
                else             e = vec(1'b1, 1'b1, 1'b1, t, 1'b0);
                chk($sformatf("seq bit%0d ph%0d", b, k), obs(sel), e);
                set_start(sel, (cyc == inject) ? 1'b1 : 1'b0);
                cyc++;
                @(negedge clk);
            end
            if (!(force_td | lut[t])) w = t;
        end
        set_start(sel, 1'b0);
        chk("done_pins", obs(sel), vec(1'b0, 1'b0, 1'b0, 6'd63, 1'b1));
        chk("result", res(sel), model_result());
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_pins", obs(sel), vec(1'b0, 1'b0, 1'b0, 6'd63, 1'b0));
            chk("result_hold", res(sel), w);
        end
    endtask

    initial begin
        int got;
        int unsigned base;

        set_thr(0);
        repeat (3) @(negedge clk);
        chk("rst_pins_a", obs(0), vec(1'b0, 1'b0, 1'b0, 6'd63, 1'b0));
        chk("rst_res_a", res(0), 6'd0);
        chk("rst_pins_b", obs(1), vec(1'b0, 1'b0, 1'b0, 6'd63, 1'b0));
        chk("rst_res_b", res(1), 6'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        set_thr(37);
        run_conv(0, -1);
        chk("t37", res(0), 6'd37);
        set_thr(63);
        run_conv(0, -1);
        chk("t63", res(0), 6'd63);
        force_td = 1'b1;
        run_conv(0, -1);
        chk("td_high", res(0), 6'd0);
        force_td = 1'b0;
        set_thr(0);
        run_conv(0, -1);
        chk("t0", res(0), 6'd0);

        set_thr(37);
        run_conv(1, -1);
        chk("meas3_t37", res(1), 6'd37);

        for (int i = 0; i < 6; i++) begin
            set_rand_lut();
            run_conv(0, -1);
        end
        for (int i = 0; i < 2; i++) begin
            set_rand_lut();
            run_conv(1, -1);
        end

        // A start pulse mid-conversion must neither restart nor queue a conversion.
        set_thr(int'($urandom_range(1, 62)));
        run_conv(0, 10);

        // Auto trigger alone: conversion starts the edge after each wrap.
        set_thr(21);
        @(negedge clk);
        auto_a = 1'b1;
        got = 0;
        for (int c = 0; c < 200 && got < 3; c++) begin
            @(negedge clk);
            if (bus_a.valid) begin
                got++;
                chk("auto_phase", ncyc % 32, 25);
                chk("auto_res", res(0), 6'd21);
            end
        end
        auto_a = 1'b0;
        chk("auto_count", got, 3);

        // Two ticks inside one long conversion give exactly one deferred conversion.
        set_thr(44);
        for (int c = 0; c < 64 && (ncyc % 32) != 2; c++) @(negedge clk);
        chk("align_a", ncyc % 32, 2);
        auto_b = 1'b1;
        for (int c = 0; c < 64 && (ncyc % 32) != 30; c++) @(negedge clk);
        chk("align_b", ncyc % 32, 30);
        base = ncyc;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        got = 0;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            if (bus_b.valid) begin
                got++;
                if (got == 1) begin
                    chk("defer_v1", ncyc - base, 37);
                    auto_b = 1'b0;
                end else begin
                    chk("defer_v2", ncyc - base, 75);
                end
                chk("defer_res", res(1), 6'd44);
            end
        end
        auto_b = 1'b0;
        chk("defer_count", got, 2);

        // Reset during the third trial: pins go idle at once, result clears.
        set_thr(37);
        run_conv(0, -1);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_pins", obs(0), vec(1'b0, 1'b0, 1'b0, 6'd63, 1'b0));
        chk("midrst_res", res(0), 6'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_thr(int'($urandom_range(0, 63)));
        run_conv(0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
